// File: rtl/minmax_pkg.sv
// Shared types and default widths for the signed min/max tracker.
package minmax_pkg;

  localparam int N_DEF     = 8;
  localparam int IDX_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/tcs_based_comparator.sv
// Combinational signed greater-than for two's-complement operands.
// Only the greater-than result is provided; equality is not needed by the tracker.
module TCSBasedComparator #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt
);

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign gt = {~a[N-1], a[N-2:0]} > {~b[N-1], b[N-2:0]};

endmodule

// File: rtl/signed_minmax_tracker.sv
// Per-frame signed max/min/count tracker with a valid/ready result port.
// Define MINMAX_INDEX_EN to keep the max_idx/min_idx position registers; otherwise they read 0.
//
// state | meaning
// IDLE  | no sample yet in the current frame
// RUN   | at least one sample taken, waiting for in_last
// DONE  | result held until out_ready
module signed_minmax_tracker
  import minmax_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [N-1:0]     max_val,
  output logic signed [N-1:0]     min_val,
  output logic        [IDX_W-1:0] max_idx,
  output logic        [IDX_W-1:0] min_idx,
  output logic        [IDX_W-1:0] count
);

  state_t state_q, state_d;

  logic                    accept;
  logic                    max_gt;
  logic                    min_gt;
  logic signed [N-1:0]     max_q;
  logic signed [N-1:0]     min_q;
  logic        [IDX_W-1:0] count_q;
  logic        [IDX_W-1:0] count_inc;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // Count sticks at all-ones; later positions reuse that saturated value.
  assign count_inc = (&count_q) ? count_q : count_q + IDX_W'(1);

  TCSBasedComparator #(.N(N)) u_cmp_max (
    .a  (in_data),
    .b  (max_q),
    .gt (max_gt)
  );

  TCSBasedComparator #(.N(N)) u_cmp_min (
    .a  (min_q),
    .b  (in_data),
    .gt (min_gt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: if (accept) state_d = in_last ? DONE : RUN;
      DONE:      if (out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q   <= '0;
      min_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        max_q   <= in_data;
        min_q   <= in_data;
        count_q <= IDX_W'(1);
      end else begin
        if (max_gt) max_q <= in_data;
        if (min_gt) min_q <= in_data;
        count_q <= count_inc;
      end
    end
  end

`ifdef MINMAX_INDEX_EN
  logic [IDX_W-1:0] max_idx_q;
  logic [IDX_W-1:0] min_idx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        max_idx_q <= '0;
        min_idx_q <= '0;
      end else begin
        if (max_gt) max_idx_q <= count_q;
        if (min_gt) min_idx_q <= count_q;
      end
    end
  end

  assign max_idx = max_idx_q;
  assign min_idx = min_idx_q;
`else
  assign max_idx = '0;
  assign min_idx = '0;
`endif

  assign max_val = max_q;
  assign min_val = min_q;
  assign count   = count_q;

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Scoreboard bench for signed_minmax_tracker: directed frames plus random frames
// against a list-based reference model.
module tb_signed_minmax_tracker;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [7:0]  in_data = '0;
  logic               in_ready;
  logic               out_valid;
  logic signed [7:0]  max_val;
  logic signed [7:0]  min_val;
  logic        [15:0] max_idx;
  logic        [15:0] min_idx;
  logic        [15:0] count;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high

  typedef struct {
    int mx;
    int mn;
    int mxi;
    int mni;
    int cnt;
  } exp_t;

  exp_t sb[$];

  signed_minmax_tracker #(.N(8), .IDX_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_val   (max_val),
    .min_val   (min_val),
    .max_idx   (max_idx),
    .min_idx   (min_idx),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first occurrence of the largest / smallest value in the frame.
  function automatic exp_t model(input int s[$]);
    exp_t r;
    int mi = 0;
    int ni = 0;
    for (int i = 1; i < s.size(); i++) begin
      if (s[i] > s[mi]) mi = i;
      if (s[i] < s[ni]) ni = i;
    end
    r.mx  = s[mi];
    r.mn  = s[ni];
    r.cnt = s.size();
`ifdef MINMAX_INDEX_EN
    r.mxi = mi;
    r.mni = ni;
`else
    r.mxi = 0;
    r.mni = 0;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom % 4) != 0;
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: a result is consumed on the edge after a cycle with valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("max_val", int'(max_val), e.mx);
        chk("min_val", int'(min_val), e.mn);
        chk("max_idx", int'(max_idx), e.mxi);
        chk("min_idx", int'(min_idx), e.mni);
        chk("count", int'(count), e.cnt);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int d, input logic last, output int waited);
    logic ok;
    in_valid = 1'b1;
    in_data  = 8'(d);
    in_last  = last;
    waited   = 0;
    ok       = 1'b0;
    while (!ok && waited < 500) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    chk("accept_timeout", int'(ok), 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int s[$], input int gap_max);
    int w;
    sb.push_back(model(s));
    for (int i = 0; i < s.size(); i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
      send(s[i], i == s.size() - 1, w);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int w;
    int s[$];
    logic signed [7:0] held_max;

    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_max", int'(max_val), 0);
    chk("rst_min", int'(min_val), 0);
    chk("rst_max_idx", int'(max_idx), 0);
    chk("rst_min_idx", int'(min_idx), 0);
    chk("rst_count", int'(count), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    send_frame('{5, -3, 127, -128, 0}, 0);

    s = '{-1};
    sb.push_back(model(s));
    send(-1, 1'b1, w);
    chk("single_out_valid", int'(out_valid), 1);
    chk("single_in_ready", int'(in_ready), 0);

    send_frame('{4, 4, -2, -2}, 0);

    // Back-pressure: result must hold with in_ready low.
    wait_drain();
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send_frame('{3, -9, 60}, 0);
    held_max = max_val;
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_max", int'(max_val), 60);
      chk("bp_min", int'(min_val), -9);
      chk("bp_count", int'(count), 3);
    end
    chk("bp_stable", int'(max_val), int'(held_max));
    rdy_mode = 2;
    w = 0;
    while (out_valid && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp_release", int'(out_valid), 0);
    s = '{42};
    sb.push_back(model(s));
    send(42, 1'b1, w);
    chk("accept_after_handshake", w, 1);
    rdy_mode = 0;

    // Asynchronous reset in the middle of a frame.
    wait_drain();
    send(10, 1'b0, w);
    send(20, 1'b0, w);
    send(-30, 1'b0, w);
    chk("pre_reset_count", int'(count), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_max", int'(max_val), 0);
    chk("mid_rst_min", int'(min_val), 0);
    chk("mid_rst_count", int'(count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_frame('{9}, 0);

    send_frame('{1, 7, -7}, 1);

    for (int f = 0; f < 40; f++) begin
      int len;
      int narrow;
      s = {};
      len = $urandom_range(1, 9);
      narrow = $urandom_range(0, 1);
      for (int i = 0; i < len; i++) begin
        if (narrow != 0) s.push_back(int'($urandom_range(0, 4)) - 2);
        else             s.push_back(int'($urandom_range(0, 255)) - 128);
      end
      send_frame(s, 2);
    end

    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/signed_minmax_tracker.md
# signed_minmax_tracker

Streaming consumer of signed two's-complement samples that tracks per-frame maximum, minimum, their positions and the sample count. It sits directly downstream of the signed comparator datapath and drives two instances of that comparator against its running extremes. Results are emitted once per frame on a valid/ready output handshake.

## Interface
- N, 8, sample width in bits, two's complement
- IDX_W, 16, width of index and count fields
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- in_valid  input  1  sample present
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  N  signed sample
- in_last  input  1  accepted sample is the last of its frame
- out_valid  output  1  frame result held
- out_ready  input  1  consumer takes the result
- max_val, min_val  output  N  frame extremes, signed
- max_idx, min_idx  output  IDX_W  zero-based sample position of each extreme
- count  output  IDX_W  samples accepted in frame

## Operation
- States: IDLE (no sample yet in frame), RUN (≥1 sample taken), DONE (result held).
- Accept = in_valid && in_ready; in_ready = 1 in IDLE and RUN, 0 in DONE (combinational from state).
- Accept in IDLE: max=min=in_data, max_idx=min_idx=0, count=1; go RUN, or DONE if in_last.
- Accept in RUN: position p = count. If in_data > max (signed, strict), max=in_data, max_idx=p. If min > in_data (strict), min=in_data, min_idx=p. count+1. in_last → DONE.
- Ties keep earliest position; a sample may update both extremes only in IDLE.
- Signed comparisons use the comparator's GT output only; EQ unused here.
- count saturates at 2^IDX_W−1; positions beyond saturation record the saturated value.
- DONE: out_valid=1, all result outputs stable. out_valid && out_ready → IDLE, registers keep last values until next frame's first accept.
- in_valid with in_ready=0 is ignored; no sample is lost when upstream holds in_valid.

## Timing
- Reset: state IDLE, out_valid=0, max_val=min_val=0, max_idx=min_idx=0, count=0; in_ready=1 once in IDLE.
- Result latency: out_valid rises on the clock edge that accepts the in_last sample; result includes that sample.
- Minimum frame period: single-sample frame accepted edge k, out_valid k, handshake at edge k+1 earliest, next accept edge k+2.
- Back-pressure: out_valid held indefinitely, outputs frozen, in_ready=0 until handshake edge.
- Reset asserted mid-frame or in DONE: partial frame discarded, outputs return to reset values immediately (asynchronous).
- Comparator path is combinational between registers; no internal pipeline.

## Configuration
- MINMAX_INDEX_EN defined: max_idx/min_idx registers and update logic present as specified.
- Not defined: index registers omitted, max_idx and min_idx tied to 0; count still implemented; ports remain.

## Structure
- Shared package minmax_pkg: state enum typedef (IDLE, RUN, DONE), default N and IDX_W constants.
- Sub-module: existing TCSBasedComparator, instantiated twice with parameter N (in_data vs max; min vs in_data).
- Top holds FSM, registers, saturation logic; target 150–250 lines.

## Test plan
- Frame 5, −3, 127, −128, 0(last) → max=127 idx 2, min=−128 idx 3, count 5.
- Single sample −1 with in_last → max=min=−1, both idx 0, count 1, out_valid on accept edge.
- Ties 4, 4, −2, −2(last) → max=4 idx 0, min=−2 idx 2.
- out_ready low 10 cycles after frame → out_valid, outputs stable, in_ready=0 throughout; handshake → IDLE, next sample accepted one cycle later.
- Reset after 3 samples of a frame, then frame 9(last) → outputs zero during reset; result max=min=9, count 1.
- MINMAX_INDEX_EN undefined, frame 1, 7, −7(last) → max=7, min=−7, both idx 0, count 3.
